// File: rtl/harris_pkg.sv
// Shared types and constants for the Harris pass sequencer: FSM states, pass stages
// and the 3x3 window tap offsets in row-major order.
package harris_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SOBEL,
    GAUSS,
    RESP,
    WAIT_ACK,
    DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    STG_SOBEL = 2'd0,
    STG_GAUSS = 2'd1,
    STG_RESP  = 2'd2
  } stage_t;

  localparam int NUM_TAPS = 9;
  localparam logic [3:0] LAST_TAP = 4'(NUM_TAPS - 1);

  // Row offset (dr) and column offset (dc) for taps 0..8, raster order over the window.
  localparam logic signed [1:0] TAP_DR [NUM_TAPS] = '{
    -2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1
  };
  localparam logic signed [1:0] TAP_DC [NUM_TAPS] = '{
    -2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd0, 2'sd1
  };

  function automatic stage_t following_stage(stage_t s);
    following_stage = STG_RESP;
    case (s)
      STG_SOBEL: following_stage = STG_GAUSS;
      STG_GAUSS: following_stage = STG_RESP;
      default:   following_stage = STG_RESP;
    endcase
  endfunction

endpackage

// File: rtl/harris_tap_addr_gen.sv
// Combinational window-tap address generator: (row, col, tap) -> (RAM address, pad flag).
// HARRIS_BORDER_CLAMP_EN selects edge replication; otherwise padded taps read the center pixel.
module harris_tap_addr_gen
  import harris_pkg::*;
#(
  parameter int N       = 8,
  parameter int bitSize = $clog2(N * N),
  parameter int RCW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic [RCW-1:0]     row,
  input  logic [RCW-1:0]     col,
  input  logic [3:0]         tap_idx,
  output logic [bitSize-1:0] addr,
  output logic               pad
);

  // Two extra bits give a sign bit plus headroom for col+1 == N.
  localparam int AW = bitSize + 2;
  localparam logic signed [AW-1:0] MAXC = AW'(N - 1);
  localparam logic signed [AW-1:0] NS   = AW'(N);

  logic signed [1:0]    dr;
  logic signed [1:0]    dc;
  logic signed [AW-1:0] row_s;
  logic signed [AW-1:0] col_s;
  logic signed [AW-1:0] tap_r;
  logic signed [AW-1:0] tap_c;
  logic signed [AW-1:0] eff_r;
  logic signed [AW-1:0] eff_c;

  always_comb begin
    dr = 2'sd0;
    dc = 2'sd0;
    if (tap_idx <= LAST_TAP) begin
      dr = TAP_DR[tap_idx];
      dc = TAP_DC[tap_idx];
    end

    row_s = $signed({{(AW - RCW){1'b0}}, row});
    col_s = $signed({{(AW - RCW){1'b0}}, col});
    tap_r = row_s + AW'(dr);
    tap_c = col_s + AW'(dc);

    pad = tap_r[AW-1] || (tap_r > MAXC) || tap_c[AW-1] || (tap_c > MAXC);

`ifdef HARRIS_BORDER_CLAMP_EN
    eff_r = tap_r[AW-1] ? '0 : ((tap_r > MAXC) ? MAXC : tap_r);
    eff_c = tap_c[AW-1] ? '0 : ((tap_c > MAXC) ? MAXC : tap_c);
`else
    eff_r = pad ? row_s : tap_r;
    eff_c = pad ? col_s : tap_c;
`endif

    addr = bitSize'(eff_r * NS + eff_c);
  end

endmodule

// File: rtl/harris_pass_sequencer.sv
// Frame scheduler: loads an N*N frame, then walks SOBEL, GAUSS and RESP passes issuing
// 9 tap reads per center. Border policy follows HARRIS_BORDER_CLAMP_EN (see tap_addr_gen).
module harris_pass_sequencer
  import harris_pkg::*;
#(
  parameter int  N          = 8,
  parameter int  pixelWidth = 8,
  localparam int bitSize    = $clog2(N * N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [pixelWidth-1:0] data_in,
  input  logic                  op_ready,
  input  logic                  pass_ack,
  output logic                  ram_we,
  output logic [bitSize-1:0]    ram_waddr,
  output logic [pixelWidth-1:0] ram_wdata,
  output logic [bitSize-1:0]    ram_raddr,
  output logic                  tap_vld,
  output logic [3:0]            tap_idx,
  output logic                  tap_pad,
  output logic [1:0]            stage,
  output logic                  pass_done,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  ovf
);

  localparam int RCW = (N > 1) ? $clog2(N) : 1;
  localparam logic [bitSize-1:0] LAST_PIX = bitSize'(N * N - 1);
  localparam logic [RCW-1:0]     LAST_RC  = RCW'(N - 1);

  seq_state_t state_q, state_d;
  stage_t     pass_q, pass_d;

  logic [bitSize-1:0] load_cnt_q, load_cnt_d;
  logic [RCW-1:0]     row_q, row_d;
  logic [RCW-1:0]     col_q, col_d;
  logic [3:0]         tap_q, tap_d;
  logic [bitSize-1:0] raddr_q, raddr_d;

  // Issue stage: describes the tap whose address sits in raddr_q this cycle.
  logic       iss_vld_q, iss_vld_d;
  logic [3:0] iss_idx_q, iss_idx_d;
  logic       iss_pad_q, iss_pad_d;
  stage_t     iss_stage_q, iss_stage_d;
  logic       iss_last_q, iss_last_d;

  // Output stage: aligned with read data returning from the RAM.
  logic       tap_vld_q, tap_vld_d;
  logic [3:0] tap_idx_q, tap_idx_d;
  logic       tap_pad_q, tap_pad_d;
  logic [1:0] stage_q, stage_d;
  logic       pass_done_q, pass_done_d;
  logic       frame_done_q, frame_done_d;
  logic       busy_q, busy_d;
  logic       ovf_q, ovf_d;

  logic [bitSize-1:0] gen_addr;
  logic               gen_pad;
  logic               load_ok;

  harris_tap_addr_gen #(
    .N       (N),
    .bitSize (bitSize),
    .RCW     (RCW)
  ) u_tap_addr_gen (
    .row     (row_q),
    .col     (col_q),
    .tap_idx (tap_q),
    .addr    (gen_addr),
    .pad     (gen_pad)
  );

  always_comb begin
    load_ok   = (state_q == IDLE) || (state_q == LOAD);
    ram_we    = we & load_ok;
    ram_waddr = load_cnt_q;
    ram_wdata = ram_we ? data_in : '0;
  end

  always_comb begin
    state_d      = state_q;
    pass_d       = pass_q;
    load_cnt_d   = load_cnt_q;
    row_d        = row_q;
    col_d        = col_q;
    tap_d        = tap_q;
    raddr_d      = raddr_q;
    iss_vld_d    = 1'b0;
    iss_idx_d    = iss_idx_q;
    iss_pad_d    = iss_pad_q;
    iss_stage_d  = iss_stage_q;
    iss_last_d   = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (we) begin
          state_d    = LOAD;
          load_cnt_d = bitSize'(1);
        end
      end
      LOAD: begin
        if (we) begin
          if (load_cnt_q == LAST_PIX) begin
            load_cnt_d = '0;
            state_d    = SOBEL;
            pass_d     = STG_SOBEL;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      SOBEL, GAUSS, RESP: begin
        if (op_ready) begin
          raddr_d     = gen_addr;
          iss_vld_d   = 1'b1;
          iss_idx_d   = tap_q;
          iss_pad_d   = gen_pad;
          iss_stage_d = pass_q;
          if (tap_q == LAST_TAP) begin
            tap_d = '0;
            if (col_q == LAST_RC) begin
              col_d = '0;
              if (row_q == LAST_RC) begin
                row_d      = '0;
                iss_last_d = 1'b1;
                state_d    = WAIT_ACK;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        if (pass_ack) begin
          if (pass_q == STG_RESP) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
          end else begin
            pass_d  = following_stage(pass_q);
            state_d = (pass_q == STG_SOBEL) ? GAUSS : RESP;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    tap_vld_d   = iss_vld_q;
    tap_idx_d   = iss_vld_q ? iss_idx_q : 4'd0;
    tap_pad_d   = iss_vld_q & iss_pad_q;
    stage_d     = iss_vld_q ? iss_stage_q : 2'd0;
    pass_done_d = iss_vld_q & iss_last_q;
    busy_d      = (state_d != IDLE);
    ovf_d       = ovf_q | (we & ~load_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pass_q       <= STG_SOBEL;
      load_cnt_q   <= '0;
      row_q        <= '0;
      col_q        <= '0;
      tap_q        <= '0;
      raddr_q      <= '0;
      iss_vld_q    <= 1'b0;
      iss_idx_q    <= '0;
      iss_pad_q    <= 1'b0;
      iss_stage_q  <= STG_SOBEL;
      iss_last_q   <= 1'b0;
      tap_vld_q    <= 1'b0;
      tap_idx_q    <= '0;
      tap_pad_q    <= 1'b0;
      stage_q      <= '0;
      pass_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pass_q       <= pass_d;
      load_cnt_q   <= load_cnt_d;
      row_q        <= row_d;
      col_q        <= col_d;
      tap_q        <= tap_d;
      raddr_q      <= raddr_d;
      iss_vld_q    <= iss_vld_d;
      iss_idx_q    <= iss_idx_d;
      iss_pad_q    <= iss_pad_d;
      iss_stage_q  <= iss_stage_d;
      iss_last_q   <= iss_last_d;
      tap_vld_q    <= tap_vld_d;
      tap_idx_q    <= tap_idx_d;
      tap_pad_q    <= tap_pad_d;
      stage_q      <= stage_d;
      pass_done_q  <= pass_done_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      ovf_q        <= ovf_d;
    end
  end

  assign ram_raddr  = raddr_q;
  assign tap_vld    = tap_vld_q;
  assign tap_idx    = tap_idx_q;
  assign tap_pad    = tap_pad_q;
  assign stage      = stage_q;
  assign pass_done  = pass_done_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_harris_pass_sequencer.sv
// Self-checking bench for harris_pass_sequencer (N=8): tap-order model plus directed
// load, stall, abuse and reset scenarios. Honours HARRIS_BORDER_CLAMP_EN for the border model.
module tb_harris_pass_sequencer;

  localparam int N     = 8;
  localparam int NPIX  = N * N;
  localparam int PTAPS = 9 * NPIX;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0;
  logic [7:0] data_in = '0;
  logic       op_ready = 1'b0;
  logic       ack_auto = 1'b0;
  logic       ack_force = 1'b0;
  logic       pass_ack;

  logic       ram_we;
  logic [5:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic [5:0] ram_raddr;
  logic       tap_vld;
  logic [3:0] tap_idx;
  logic       tap_pad;
  logic [1:0] stage;
  logic       pass_done;
  logic       frame_done;
  logic       busy;
  logic       ovf;

  assign pass_ack = ack_auto | ack_force;

  always #5 clk = ~clk;

  harris_pass_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .data_in    (data_in),
    .op_ready   (op_ready),
    .pass_ack   (pass_ack),
    .ram_we     (ram_we),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_raddr  (ram_raddr),
    .tap_vld    (tap_vld),
    .tap_idx    (tap_idx),
    .tap_pad    (tap_pad),
    .stage      (stage),
    .pass_done  (pass_done),
    .frame_done (frame_done),
    .busy       (busy),
    .ovf        (ovf)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Window geometry straight from the image: center c, tap t -> read address and pad flag.
  function automatic void model(input int c, input int t, output int addr, output bit pad);
    int r;
    int q;
    r   = c / N + t / 3 - 1;
    q   = c % N + t % 3 - 1;
    pad = (r < 0) || (r >= N) || (q < 0) || (q >= N);
`ifdef HARRIS_BORDER_CLAMP_EN
    if (r < 0) r = 0;
    if (r > N - 1) r = N - 1;
    if (q < 0) q = 0;
    if (q > N - 1) q = N - 1;
    addr = r * N + q;
`else
    addr = pad ? c : r * N + q;
`endif
  endfunction

  int         exp_pass = 0;
  int         tap_n = 0;
  int         frame_cnt = 0;
  int         pass_cnt = 0;
  bit         gauss_seen = 1'b0;
  bit         resp_seen = 1'b0;
  logic [5:0] prev_raddr = '0;

  always @(negedge clk) begin
    int ea;
    bit ep;
    if (!rst_n) begin
      exp_pass = 0;
      tap_n    = 0;
    end else begin
      if (tap_vld) begin
        model(tap_n / 9, tap_n % 9, ea, ep);
        chk("tap_raddr", prev_raddr, ea);
        chk("tap_pad", tap_pad, ep);
        chk("tap_idx", tap_idx, tap_n % 9);
        chk("tap_stage", stage, exp_pass);
        if (frame_cnt == 0 && exp_pass == 0) begin
          case (tap_n)
            0:  begin chk("lit_c0t0_addr", prev_raddr, 0);  chk("lit_c0t0_pad", tap_pad, 1); end
            5:  begin chk("lit_c0t5_addr", prev_raddr, 1);  chk("lit_c0t5_pad", tap_pad, 0); end
            65: begin chk("lit_c7t2_addr", prev_raddr, 7);  chk("lit_c7t2_pad", tap_pad, 1); end
            81: chk("lit_c9t0_addr", prev_raddr, 0);
            83: chk("lit_c9t2_addr", prev_raddr, 2);
            87: chk("lit_c9t6_addr", prev_raddr, 16);
            89: begin chk("lit_c9t8_addr", prev_raddr, 18); chk("lit_c9t8_pad", tap_pad, 0); end
            default: ;
          endcase
        end
        if (stage == 2'd1) gauss_seen = 1'b1;
        if (stage == 2'd2) resp_seen = 1'b1;
        tap_n++;
      end
      if (pass_done) begin
        chk("pass_done_with_vld", tap_vld, 1);
        chk("taps_per_pass", tap_n, PTAPS);
        pass_cnt++;
        exp_pass++;
        tap_n = 0;
      end
      if (frame_done) begin
        chk("frame_done_after_resp", exp_pass, 3);
        frame_cnt++;
        exp_pass = 0;
      end
    end
    prev_raddr = ram_raddr;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && pass_done) begin
        repeat (4) @(negedge clk);
        ack_auto = 1'b1;
        @(negedge clk);
        ack_auto = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_raddr"}, ram_raddr, 0);
    chk({tag, "_tap_vld"}, tap_vld, 0);
    chk({tag, "_tap_idx"}, tap_idx, 0);
    chk({tag, "_tap_pad"}, tap_pad, 0);
    chk({tag, "_stage"}, stage, 0);
    chk({tag, "_pass_done"}, pass_done, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n    = 1'b1;
    op_ready = 1'b1;

    // Frame 1 load, one pixel every other cycle.
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      we      = 1'b1;
      data_in = 8'(i * 3 + 1);
      #1;
      chk("load_ram_we", ram_we, 1);
      chk("load_waddr", ram_waddr, i);
      chk("load_wdata", ram_wdata, (i * 3 + 1) & 8'hFF);
      chk("load_busy", busy, (i != 0));
      @(negedge clk);
      we = 1'b0;
      #1;
      chk("gap_ram_we", ram_we, 0);
    end

    // SOBEL issues its first tap on the edge after pixel 63; tap_vld follows one cycle later.
    @(negedge clk);
    #1;
    chk("first_tap_latency0", tap_vld, 0);
    @(negedge clk);
    #1;
    chk("first_tap_latency1", tap_vld, 1);
    chk("first_tap_idx", tap_idx, 0);
    chk("sobel_busy", busy, 1);
    repeat (83) @(negedge clk);

    // Stall at center 9 tap 4; a stray ack during the pass must be ignored.
    op_ready  = 1'b0;
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    #1;
    chk("stall_raddr0", ram_raddr, 8);
    chk("stall_vld0", tap_vld, 1);
    chk("stall_idx0", tap_idx, 3);
    @(negedge clk);
    #1;
    chk("stall_raddr1", ram_raddr, 8);
    chk("stall_vld1", tap_vld, 0);
    @(negedge clk);
    op_ready = 1'b1;
    #1;
    chk("stall_raddr2", ram_raddr, 8);
    chk("stall_vld2", tap_vld, 0);
    @(negedge clk);
    #1;
    chk("resume_raddr", ram_raddr, 9);
    chk("stall_vld3", tap_vld, 0);
    @(negedge clk);
    #1;
    chk("resume_vld", tap_vld, 1);
    chk("resume_idx", tap_idx, 4);

    // Write attempt during GAUSS.
    for (int k = 0; k < 3000 && !gauss_seen; k++) begin
      @(negedge clk);
      #1;
    end
    chk("reach_gauss", gauss_seen, 1);
    @(negedge clk);
    we      = 1'b1;
    data_in = 8'hAA;
    #1;
    chk("abuse_ram_we", ram_we, 0);
    chk("abuse_ovf_before", ovf, 0);
    @(negedge clk);
    we = 1'b0;
    #1;
    chk("abuse_ovf_after", ovf, 1);

    for (int k = 0; k < 4000 && frame_cnt == 0; k++) begin
      @(negedge clk);
      #1;
    end
    chk("frame1_done_seen", frame_cnt, 1);
    chk("done_busy", busy, 1);
    chk("done_pulse", frame_done, 1);
    @(negedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_frame_done", frame_done, 0);
    chk("idle_tap_vld", tap_vld, 0);
    chk("frame1_passes", pass_cnt, 3);

    // Frame 2: back-to-back load, then reset in the middle of RESP.
    resp_seen = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      we      = 1'b1;
      data_in = 8'(255 - i);
      #1;
      chk("load2_waddr", ram_waddr, i);
    end
    @(negedge clk);
    we = 1'b0;
    for (int k = 0; k < 6000 && !resp_seen; k++) begin
      @(negedge clk);
      #1;
    end
    chk("reach_resp", resp_seen, 1);
    repeat (20) @(negedge clk);
    #1;
    chk("ovf_sticky", ovf, 1);
    chk("resp_busy", busy, 1);
    chk("resp_stage", stage, 2);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("post_reset_busy", busy, 0);
    chk("post_reset_vld", tap_vld, 0);
    chk("post_reset_ovf", ovf, 0);
    chk("total_frames", frame_cnt, 1);
    chk("total_passes", pass_cnt, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
